max_min_scheduler: RTL
======================

Name: max_min_scheduler

Overview:
Shares one max/min search engine among NUM_REQ byte-stream requesters. A round-robin arbiter grants one requester at a time and forwards its byte sequence to the engine on the start/inputA interface. The block then waits for the engine's done, returns the max/min result tagged with the requester ID, and rotates priority. It sits between the client streams and the single max/min datapath instance.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, 2, width of requester ID; equals clog2(NUM_REQ)
TIMEOUT, 64, maximum cycles spent in WAIT before a timeout response

Ports:
clk  input  1  clock; all logic rises on posedge
reset  input  1  asynchronous, active-high reset
req_valid  input  NUM_REQ  requester i presents a byte
req_data  input  NUM_REQ*8  byte of requester i in bits [8i+7:8i], unsigned
req_last  input  NUM_REQ  byte of requester i is the final byte of its sequence
req_ready  output  NUM_REQ  one-hot; byte accepted when valid&ready
eng_start  output  1  high while a sequence is streamed to the engine
eng_inputA  output  8  byte to the engine
eng_done  input  1  engine result ready; level signal
eng_maxValue  input  8  engine max result
eng_minValue  input  8  engine min result
rsp_valid  output  1  response available
rsp_ready  input  1  response consumer accepts
rsp_id  output  ID_W  granted requester index
rsp_max  output  8  captured max
rsp_min  output  8  captured min
rsp_timeout  output  1  response produced by timeout; max/min forced to 0

Behaviour:
- Reset (asynchronous, active-high; also applies mid-operation): state=IDLE, rr_ptr=0, grant=0, wait_cnt=0. All outputs are 0, including req_ready, eng_start, eng_inputA and all rsp_* outputs. Any in-flight sequence is discarded.
- The state machine has four states: IDLE, STREAM, WAIT, RESP. eng_start, eng_inputA and all rsp_* outputs are registered. req_ready is decoded from the state and the grant register.
- IDLE:
  - If any req_valid is high, latch grant = first asserted index scanning rr_ptr, rr_ptr+1, … modulo NUM_REQ, then go to STREAM.
  - No byte is accepted in IDLE, so grant-to-first-acceptance is 1 cycle.
- STREAM:
  - req_ready[grant]=1; all other bits are 0.
  - On a transfer (req_valid[grant]): eng_inputA<=byte, eng_start<=1.
  - Bubble (req_valid[grant]=0): eng_start stays 1 and eng_inputA holds the previous byte. Repeating a byte cannot change max/min.
  - Before the first transfer, eng_start stays 0.
  - A transfer with req_last set moves to WAIT. The last byte is on eng_inputA with eng_start=1 in the first WAIT cycle. eng_start falls to 0 one cycle later and stays 0 throughout WAIT.
  - A single-byte sequence (first transfer has last=1) is legal.
- WAIT:
  - wait_cnt increments every cycle.
  - eng_done is ignored while eng_start=1.
  - When eng_done=1 and eng_start=0: capture rsp_max/rsp_min from the engine, rsp_id=grant, rsp_timeout=0, rsp_valid<=1, go to RESP.
  - If wait_cnt reaches TIMEOUT-1 without done: rsp_max=rsp_min=0, rsp_timeout=1, rsp_valid<=1, go to RESP.
  - Done takes precedence over timeout when both occur in the same cycle.
- RESP:
  - rsp_valid and the captured fields hold stable until rsp_ready.
  - On rsp_valid&rsp_ready: rsp_valid<=0, rr_ptr<=(grant+1) mod NUM_REQ, wait_cnt<=0, go to IDLE.
  - rsp_ready asserted before rsp_valid has no effect.
- Non-granted requesters are never back-pressured into loss. Their req_valid may stay high indefinitely.
- Fairness: with all requesters continuously valid, grants cycle 0,1,2,3,0,…

Test Plan:
- Reset, then only requester 1 sends bytes 0x12,0x80,0x05(last), with the engine model asserting done 2 cycles after eng_start falls -> eng_inputA shows 0x12,0x80,0x05 with eng_start high; the response has rsp_id=1, rsp_max=0x80, rsp_min=0x05, rsp_timeout=0.
- All 4 requesters valid continuously, 2-byte sequences each -> responses in ID order 0,1,2,3,0; no req_ready to a non-granted requester.
- Requester 2 sends 0x40, then 3 bubble cycles, then 0xFF(last) -> eng_start stays high through the bubbles with eng_inputA=0x40; the result is max=0xFF, min=0x40.
- Engine model never asserts done, TIMEOUT=64 -> rsp_valid rises 64 cycles after entering WAIT, with rsp_timeout=1 and max=min=0. The next request is then served normally.
- Hold rsp_ready low for 10 cycles -> rsp fields stay stable and no new grant is issued; the next grant goes to (rsp_id+1) mod 4.
- Assert reset while in STREAM, mid-sequence -> all outputs 0 immediately; after release, a grant to requester 0 (with req_valid[0] high) starts a clean sequence.

Source files
------------

// File: rtl/max_min_scheduler.sv
// Round-robin front end that time-shares a single max/min search engine among
// NUM_REQ byte-stream requesters and returns ID-tagged results.
module max_min_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*8-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 eng_start,
    output logic [7:0]           eng_inputA,
    input  logic                 eng_done,
    input  logic [7:0]           eng_maxValue,
    input  logic [7:0]           eng_minValue,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [7:0]           rsp_max,
    output logic [7:0]           rsp_min,
    output logic                 rsp_timeout
);

    typedef enum logic [1:0] {IDLE, STREAM, WAIT, RESP} state_t;

    localparam int CNT_W = $clog2(TIMEOUT) + 1;

    state_t            state_reg, state_next;
    logic [ID_W-1:0]   rr_ptr_reg, rr_ptr_next;
    logic [ID_W-1:0]   grant_reg, grant_next;
    logic [CNT_W-1:0]  wait_cnt_reg, wait_cnt_next;
    logic              eng_start_reg, eng_start_next;
    logic [7:0]        eng_inputA_reg, eng_inputA_next;
    logic              rsp_valid_reg, rsp_valid_next;
    logic [ID_W-1:0]   rsp_id_reg, rsp_id_next;
    logic [7:0]        rsp_max_reg, rsp_max_next;
    logic [7:0]        rsp_min_reg, rsp_min_next;
    logic              rsp_timeout_reg, rsp_timeout_next;

    logic [7:0]        req_byte [NUM_REQ];
    logic              sel_valid, sel_last;
    logic [7:0]        sel_byte;
    logic              arb_found;
    logic [ID_W-1:0]   arb_idx;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign req_byte[gi]  = req_data[8*gi +: 8];
            assign req_ready[gi] = (state_reg == STREAM) && (grant_reg == ID_W'(gi));
        end
    endgenerate

    assign sel_valid = req_valid[grant_reg];
    assign sel_last  = req_last[grant_reg];
    assign sel_byte  = req_byte[grant_reg];

    // First valid requester found scanning upward from rr_ptr, wrapping at NUM_REQ.
    always_comb begin
        int idx;
        arb_found = 1'b0;
        arb_idx   = '0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr_reg) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!arb_found && req_valid[idx]) begin
                arb_found = 1'b1;
                arb_idx   = ID_W'(idx);
            end
        end
    end

    always_comb begin
        state_next       = state_reg;
        rr_ptr_next      = rr_ptr_reg;
        grant_next       = grant_reg;
        wait_cnt_next    = wait_cnt_reg;
        eng_start_next   = eng_start_reg;
        eng_inputA_next  = eng_inputA_reg;
        rsp_valid_next   = rsp_valid_reg;
        rsp_id_next      = rsp_id_reg;
        rsp_max_next     = rsp_max_reg;
        rsp_min_next     = rsp_min_reg;
        rsp_timeout_next = rsp_timeout_reg;

        case (state_reg)
            IDLE: begin
                if (arb_found) begin
                    grant_next = arb_idx;
                    state_next = STREAM;
                end
            end
            STREAM: begin
                // A bubble leaves start high and the previous byte in place.
                if (sel_valid) begin
                    eng_inputA_next = sel_byte;
                    eng_start_next  = 1'b1;
                    if (sel_last) state_next = WAIT;
                end
            end
            WAIT: begin
                eng_start_next = 1'b0;
                wait_cnt_next  = wait_cnt_reg + 1'b1;
                // done is only trusted once start has dropped; it wins over timeout.
                if (eng_done && !eng_start_reg) begin
                    rsp_valid_next   = 1'b1;
                    rsp_id_next      = grant_reg;
                    rsp_max_next     = eng_maxValue;
                    rsp_min_next     = eng_minValue;
                    rsp_timeout_next = 1'b0;
                    state_next       = RESP;
                end else if (wait_cnt_reg == CNT_W'(TIMEOUT - 1)) begin
                    rsp_valid_next   = 1'b1;
                    rsp_id_next      = grant_reg;
                    rsp_max_next     = 8'h00;
                    rsp_min_next     = 8'h00;
                    rsp_timeout_next = 1'b1;
                    state_next       = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_next = 1'b0;
                    rr_ptr_next    = (grant_reg == ID_W'(NUM_REQ - 1)) ? '0 : grant_reg + 1'b1;
                    wait_cnt_next  = '0;
                    state_next     = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= IDLE;
            rr_ptr_reg      <= '0;
            grant_reg       <= '0;
            wait_cnt_reg    <= '0;
            eng_start_reg   <= 1'b0;
            eng_inputA_reg  <= 8'h00;
            rsp_valid_reg   <= 1'b0;
            rsp_id_reg      <= '0;
            rsp_max_reg     <= 8'h00;
            rsp_min_reg     <= 8'h00;
            rsp_timeout_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            rr_ptr_reg      <= rr_ptr_next;
            grant_reg       <= grant_next;
            wait_cnt_reg    <= wait_cnt_next;
            eng_start_reg   <= eng_start_next;
            eng_inputA_reg  <= eng_inputA_next;
            rsp_valid_reg   <= rsp_valid_next;
            rsp_id_reg      <= rsp_id_next;
            rsp_max_reg     <= rsp_max_next;
            rsp_min_reg     <= rsp_min_next;
            rsp_timeout_reg <= rsp_timeout_next;
        end
    end

    assign eng_start   = eng_start_reg;
    assign eng_inputA  = eng_inputA_reg;
    assign rsp_valid   = rsp_valid_reg;
    assign rsp_id      = rsp_id_reg;
    assign rsp_max     = rsp_max_reg;
    assign rsp_min     = rsp_min_reg;
    assign rsp_timeout = rsp_timeout_reg;

endmodule
